mmio_arbiter: RTL
=================

Name: mmio_arbiter

Overview:
- Two-master arbiter that shares the single MMIO peripheral port (LED/hex/switch register block) between the CPU data port (m0) and a second bus master (m1, debug/DMA).
- Muxes the winning request onto the slave's clken/wren/address/byteena/data bus.
- Tracks the one-cycle slave read latency and routes the read return (q) back to the issuing master with a valid strobe.
- Round-robin fairness; zero-bubble back-to-back issue.

Parameters:
- ADDR_WIDTH, 14, slave word-address width
- DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- m0_req  input  1  master 0 request; held with its fields until m0_gnt
- m0_addr  input  ADDR_WIDTH  master 0 word address
- m0_byteena  input  DATA_WIDTH/8  master 0 byte enables
- m0_wdata  input  DATA_WIDTH  master 0 write data
- m0_wren  input  1  master 0 write (1) / read (0)
- m0_gnt  output  1  request accepted this cycle
- m0_rvalid  output  1  read data valid for master 0
- m0_rdata  output  DATA_WIDTH  read data (equals slave_q)
- m1_*  same set as m0_* for master 1
- slave_address  output  ADDR_WIDTH  to slave address
- slave_byteena  output  DATA_WIDTH/8  to slave byteena
- slave_data  output  DATA_WIDTH  to slave data
- slave_wren  output  1  to slave wren
- slave_clken  output  1  to slave clken; 1 only in a cycle where a grant is issued
- slave_q  input  DATA_WIDTH  slave read data, valid the cycle after clken

Behaviour:
- Reset: synchronous, active-low, on clock.
  - While reset_n=0: m0_gnt=m1_gnt=0, slave_clken=0, slave_wren=0.
  - Registers cleared: rr_ptr=0 (m0 preferred), resp_valid=0, resp_owner=0, resp_read=0.
  - The cycle after reset release: m0_rvalid=m1_rvalid=0.
- Grant (combinational, same cycle as req):
  - Only one req high: that master is granted.
  - Both high: master rr_ptr is granted.
  - Neither high: no grant; slave_clken=0; slave_address/byteena/data/wren driven 0.
- Slave outputs: mux of the granted master's fields; slave_clken = m0_gnt | m1_gnt.
- Round-robin: on any grant, rr_ptr <= index of the non-granted master. No grant leaves rr_ptr unchanged.
- Response pipeline: on a grant, resp_valid <= 1, resp_owner <= winner, resp_read <= ~wren. Otherwise resp_valid <= 0.
- Read return:
  - mX_rvalid = resp_valid & resp_read & (resp_owner==X).
  - Read latency is exactly 1 cycle after gnt.
  - Writes produce no rvalid.
- m0_rdata = m1_rdata = slave_q, unregistered. Content is only meaningful when the matching rvalid is high.
- Throughput: one grant per cycle. Back-to-back grants to alternating or the same master are legal. A master with req held continuously and no competitor is granted every cycle.
- Request rule: a master keeps req and its fields stable until gnt. The arbiter does not latch ungranted requests.
- Reset mid-operation: an outstanding read granted in the cycle reset_n falls is dropped; no rvalid is ever produced for it.
- Slave write enable: the slave clears its internal write enable when clken=0. The arbiter therefore never holds clken high without a grant.

Optional Feature:
- Macro: MMIO_ARB_LOCK_EN
- With the macro, ports m0_lock and m1_lock (input, 1) are added, plus a lock FSM with states UNLOCKED, LOCKED_M0, LOCKED_M1; reset state UNLOCKED.
  - UNLOCKED -> LOCKED_MX: master X is granted with mX_lock=1.
  - LOCKED_MX -> UNLOCKED: any cycle mX_lock=0, sampled at the clock edge.
  - In LOCKED_MX only master X can be granted; the other master's req is ignored, and rr_ptr is not updated while locked.
  - The grant that enters the lock updates rr_ptr normally.
  - Used for atomic read-modify-write of hex/LED registers.
- Without the macro, the lock ports and FSM are absent and arbitration is pure round-robin.

Test Plan:
- Reset, then m0 read addr 0x0002 with switch=0x155: m0_gnt=1 same cycle, slave_clken=1; next cycle m0_rvalid=1, m0_rdata=0x00000155, m1_rvalid=0.
- m0 and m1 both req continuously for 4 cycles from reset: grant order m0, m1, m0, m1; slave_clken=1 every cycle.
- m1 write addr 0x0000 data 0x3FF byteena 0xF: m1_gnt=1; no rvalid follows. A following m0 read of 0x0000 returns 0x000003FF with m0_rvalid one cycle after its grant.
- m0 read granted, reset_n driven low in that same cycle for 1 cycle: m0_rvalid=0 in all subsequent cycles; rr_ptr back to m0 (simultaneous req then grants m0).
- No requests for 5 cycles: slave_clken=0, slave_wren=0, slave_address=0, no rvalid.
- (MMIO_ARB_LOCK_EN) m0 req+lock granted while m1 reqs continuously:
  - m0 reads 0x0001 then writes 0x0001, both with lock=1; m1_gnt=0 throughout.
  - m0 drops lock; m1 is granted the next cycle m1 is selected.

Source files
------------

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter for the MMIO peripheral port, with one-cycle read-return routing.
// Optional bus lock for atomic read-modify-write is enabled by defining MMIO_ARB_LOCK_EN.
//
// Lock FSM (MMIO_ARB_LOCK_EN only):
//   state     | meaning
//   UNLOCKED  | normal round-robin between m0 and m1
//   LOCKED_M0 | only m0 may be granted; rr_ptr frozen
//   LOCKED_M1 | only m1 may be granted; rr_ptr frozen
module mmio_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,

    input  logic                      m0_req,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [DATA_WIDTH/8-1:0]   m0_byteena,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic                      m0_wren,
    output logic                      m0_gnt,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,

    input  logic                      m1_req,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH/8-1:0]   m1_byteena,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic                      m1_wren,
    output logic                      m1_gnt,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,

`ifdef MMIO_ARB_LOCK_EN
    input  logic                      m0_lock,
    input  logic                      m1_lock,
`endif

    output logic [ADDR_WIDTH-1:0]     slave_address,
    output logic [DATA_WIDTH/8-1:0]   slave_byteena,
    output logic [DATA_WIDTH-1:0]     slave_data,
    output logic                      slave_wren,
    output logic                      slave_clken,
    input  logic [DATA_WIDTH-1:0]     slave_q
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic rr_ptr;
    logic resp_valid;
    logic resp_owner;
    logic resp_read;

    logic allow_m0;
    logic allow_m1;
    logic locked;
    logic req_m0;
    logic req_m1;
    logic gnt_m0;
    logic gnt_m1;
    logic gnt_any;

`ifdef MMIO_ARB_LOCK_EN
    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED_M0 = 2'd1,
        LOCKED_M1 = 2'd2
    } lock_state_t;

    lock_state_t lock_state;
    lock_state_t lock_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_next;
        end
    end

    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            UNLOCKED: begin
                if (gnt_m0 && m0_lock) begin
                    lock_next = LOCKED_M0;
                end else if (gnt_m1 && m1_lock) begin
                    lock_next = LOCKED_M1;
                end
            end
            LOCKED_M0: begin
                if (!m0_lock) begin
                    lock_next = UNLOCKED;
                end
            end
            LOCKED_M1: begin
                if (!m1_lock) begin
                    lock_next = UNLOCKED;
                end
            end
            default: lock_next = UNLOCKED;
        endcase
    end

    assign allow_m0 = (lock_state != LOCKED_M1);
    assign allow_m1 = (lock_state != LOCKED_M0);
    assign locked   = (lock_state != UNLOCKED);
`else
    assign allow_m0 = 1'b1;
    assign allow_m1 = 1'b1;
    assign locked   = 1'b0;
`endif

    // Grants are suppressed during reset so the slave never sees clken while reset_n is low.
    always_comb begin
        req_m0 = m0_req & allow_m0 & reset_n;
        req_m1 = m1_req & allow_m1 & reset_n;
        gnt_m0 = req_m0 & (~req_m1 | ~rr_ptr);
        gnt_m1 = req_m1 & (~req_m0 |  rr_ptr);
        gnt_any = gnt_m0 | gnt_m1;
    end

    assign m0_gnt = gnt_m0;
    assign m1_gnt = gnt_m1;

    always_comb begin
        slave_address = '0;
        slave_byteena = '0;
        slave_data    = '0;
        slave_wren    = 1'b0;
        if (gnt_m0) begin
            slave_address = m0_addr;
            slave_byteena = m0_byteena;
            slave_data    = m0_wdata;
            slave_wren    = m0_wren;
        end else if (gnt_m1) begin
            slave_address = m1_addr;
            slave_byteena = m1_byteena;
            slave_data    = m1_wdata;
            slave_wren    = m1_wren;
        end
    end

    assign slave_clken = gnt_any;

    // rr_ptr names the master preferred on the next contended cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (gnt_any && !locked) begin
            rr_ptr <= gnt_m0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
            resp_read  <= 1'b0;
        end else begin
            resp_valid <= gnt_any;
            if (gnt_any) begin
                resp_owner <= gnt_m1;
                resp_read  <= ~slave_wren;
            end
        end
    end

    assign m0_rvalid = resp_valid & resp_read & ~resp_owner;
    assign m1_rvalid = resp_valid & resp_read &  resp_owner;
    assign m0_rdata  = slave_q;
    assign m1_rdata  = slave_q;

    logic unused_be;
    assign unused_be = (BE_WIDTH == 0);

endmodule
